// File: rtl/spart_rx.sv
// rtl/spart_rx.sv - SPART receive engine: 16x-oversampled 8N1 deserialiser with receive buffer flags
module spart_rx #(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rxd,
    input  logic                 baud_en,
    input  logic                 rd_ack,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rda,
    output logic                 frame_err,
    output logic                 overrun
);

    localparam int TW = $clog2(OVERSAMPLE);
    localparam int BW = $clog2(DATA_BITS) + 1;
    localparam logic [TW-1:0] HALF_TICK = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] FULL_TICK = TW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] LAST_BIT  = BW'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BRK
    } state_t;

    state_t               state;
    logic                 rx_meta;
    logic                 rxs;
    logic [TW-1:0]        tick_cnt;
    logic [BW-1:0]        bit_cnt;
    logic [DATA_BITS-1:0] shift_reg;

    // Two-flop synchroniser; idles high so reset never looks like a start bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta <= 1'b1;
            rxs     <= 1'b1;
        end else begin
            rx_meta <= rxd;
            rxs     <= rx_meta;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            tick_cnt  <= '0;
            bit_cnt   <= '0;
            shift_reg <= '0;
            rx_data   <= '0;
            rda       <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            // A bus read clears the flags; a coinciding load below re-sets rda.
            if (rd_ack) begin
                rda     <= 1'b0;
                overrun <= 1'b0;
            end

            if (baud_en) begin
                case (state)
                    IDLE: begin
                        if (!rxs) begin
                            state    <= START;
                            tick_cnt <= '0;
                        end
                    end
                    START: begin
                        if (tick_cnt == HALF_TICK) begin
                            if (rxs) begin
                                state <= IDLE;
                            end else begin
                                state    <= DATA;
                                tick_cnt <= '0;
                                bit_cnt  <= '0;
                            end
                        end else begin
                            tick_cnt <= tick_cnt + TW'(1);
                        end
                    end
                    DATA: begin
                        if (tick_cnt == FULL_TICK) begin
                            shift_reg <= {rxs, shift_reg[DATA_BITS-1:1]};
                            tick_cnt  <= '0;
                            bit_cnt   <= bit_cnt + BW'(1);
                            if (bit_cnt == LAST_BIT) begin
                                state <= STOP;
                            end
                        end else begin
                            tick_cnt <= tick_cnt + TW'(1);
                        end
                    end
                    STOP: begin
                        if (tick_cnt == FULL_TICK) begin
                            tick_cnt <= '0;
                            state    <= rxs ? IDLE : BRK;
                            if (!rda || rd_ack) begin
                                rx_data   <= shift_reg;
                                frame_err <= ~rxs;
                                rda       <= 1'b1;
                            end else begin
                                overrun <= 1'b1;
                            end
                        end else begin
                            tick_cnt <= tick_cnt + TW'(1);
                        end
                    end
                    BRK: begin
                        // A held-low line must go high before another start is looked for.
                        if (rxs) begin
                            state <= IDLE;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule
